spi_slave_fl: RTL and testbench
===============================

Name: spi_slave_fl

Overview:
- SPI responder (flash-style target) for the single-lane flash master: sampled-clock SPI mode 3 (sclk idle high), one frame per ss low period.
- Decodes an 8-bit opcode, then a 24-bit address and/or 32-bit write data as the opcode requires, and shifts a response back on miso.
- Presents each completed frame to local logic on a one-cycle valid strobe. Used as a bus-side device model and as an FPGA-side flash emulator.

Parameters:
- SYNC_EN, 1, 1: 2-flop synchronizers on sclk/ss/mosi; 0: inputs already in clk domain.
- DEVICE_ID, 32'h001740EF, READ_ID response word.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sclk  in  1  SPI clock, idle high
- ss  in  1  slave select, active low
- mosi  in  1  serial data from master, MSB first
- miso  out  1  serial data to master, LSB first
- resp_data  in  32  response word for READ (0x03); sampled when resp_req pulses
- resp_req  out  1  1-cycle pulse: READ address complete, addr_out valid
- frame_valid  out  1  1-cycle pulse after ss rises
- frame_err  out  1  valid with frame_valid: frame ended mid-phase or bad opcode
- cmd_out  out  8  captured opcode
- addr_out  out  24  captured address
- wdata_out  out  32  captured write data
- status  out  8  internal status register; bit1 = WEL

Behaviour:
- Reset: miso=0, resp_req=0, frame_valid=0, frame_err=0, cmd_out/addr_out/wdata_out=0, status=8'h00, state IDLE.
- Edge detect on the synced sclk: rise = sample mosi; fall = update miso.
  - Constraint: sclk half period >= 2 clk (SYNC_EN=0) or >= 4 clk (SYNC_EN=1).
- States:
  - IDLE: miso=0, bit counter cleared; ss fall -> CMD.
  - CMD: shift 8 bits, MSB first. On the 8th rise, decode:
    - 0x9F READ_ID: RESP, word = DEVICE_ID.
    - 0x05 RDSR: RESP, word = {24'b0,status}.
    - 0x03 READ: ADDR.
    - 0x02 PP: ADDR.
    - 0x01 WRSR: WDATA.
    - 0x06 WREN: DONE; status[1] set at frame end.
    - Any other opcode: DONE with err pending.
  - ADDR: 24 bits, MSB first. On the 24th rise: READ -> resp_req pulse, resp_data sampled on the next clk, RESP; PP -> WDATA.
  - WDATA: 32 bits, MSB first. After the 32nd bit -> DONE.
    - WRSR at frame end: status <= {wdata_out[7:2], status[1], wdata_out[0]} only if WEL=1; WEL then cleared.
    - PP at frame end clears WEL.
  - RESP: on each sclk fall, miso = word[k], k = 0,1,2,… (LSB first).
    - The first fall after the last opcode/address rise drives bit 0.
    - After bit 31, miso=0 for the rest of the frame. Master may stop at any count 1..32 (no error).
  - DONE: ignore sclk, miso=0; wait for ss high.
- ss rise in any non-IDLE state:
  - One cycle after the synced ss rise: frame_valid=1 with cmd/addr/wdata outputs.
  - frame_err=1 if state was CMD/ADDR/WDATA with partial bits, or opcode unknown.
  - Status side effects apply only when err=0. Return to IDLE.
- ss rise in IDLE: no pulse.
- cmd/addr/wdata outputs hold their values until the next frame's respective phase completes.
- Simultaneous ss rise and sclk edge: ss wins; the edge is ignored.
- Reset mid-frame: immediate return to reset values; the frame is discarded, no pulse.
- ss fall while rst high: ignored.

Decomposition:
- Shared package: opcode constants (OP_READ_ID, OP_RDSR, OP_READ, OP_PP, OP_WRSR, OP_WREN), phase lengths (CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32), state encoding.
- One sub-module, spi_slave_sync: synchronizer + rise/fall edge detector for sclk and ss. Bypassed when SYNC_EN=0.
- Shift registers, counters and FSM stay in spi_slave_fl.

Test Plan:
- READ_ID, master commtype=001, nmiso_bits=32 -> master data_out=32'h001740EF; frame_valid with cmd_out=8'h9F, frame_err=0.
- READ addr 24'h00A5C3, resp_data=32'hDEADBEEF -> resp_req pulse with addr_out=24'h00A5C3; master reads 32'hDEADBEEF; nmiso_bits=8 -> master reads 8'hEF.
- WRSR data 32'h0000003D without WREN -> status stays 8'h00. WREN, then WRSR 32'h0000003D -> status=8'h3D then WEL clear = 8'h3D; RDSR nmiso_bits=8 returns 8'h3D.
- PP addr 24'h000100, data 32'h12345678 -> frame_valid, cmd_out=8'h02, addr_out=24'h000100, wdata_out=32'h12345678, err=0.
- Opcode 8'hAB -> miso stays 0, frame_valid with frame_err=1. Separately, ss raised after 12 address bits -> frame_err=1, status unchanged.
- rst pulse during READ response bit 10 -> miso=0 immediately, no frame_valid; next READ_ID frame returns DEVICE_ID correctly.

Source files
------------

// File: rtl/spi_slave_fl_pkg.sv
// Shared definitions for the flash-style SPI responder.
//   - opcode constants understood by the responder
//   - phase lengths and bit-counter load values
//   - FSM state encoding and opcode -> next-phase decode helpers
package spi_slave_fl_pkg;

    localparam logic [7:0] OP_READ_ID = 8'h9F;
    localparam logic [7:0] OP_RDSR    = 8'h05;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_PP      = 8'h02;
    localparam logic [7:0] OP_WRSR    = 8'h01;
    localparam logic [7:0] OP_WREN    = 8'h06;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int DATA_BITS = 32;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CMD_LOAD  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] ADDR_LOAD = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_BITS - 1);

    localparam int STATUS_WEL = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RESP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Phase entered once the opcode byte is complete.
    function automatic state_t op_decode(input logic [7:0] op);
        state_t nxt;
        case (op)
            OP_READ_ID, OP_RDSR: nxt = ST_RESP;
            OP_READ, OP_PP:      nxt = ST_ADDR;
            OP_WRSR:             nxt = ST_WDATA;
            default:             nxt = ST_DONE;
        endcase
        return nxt;
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        logic known;
        case (op)
            OP_READ_ID, OP_RDSR, OP_READ, OP_PP, OP_WRSR, OP_WREN: known = 1'b1;
            default:                                               known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Input conditioning for the SPI responder: optional 2-flop synchronizers
// on sclk/ss/mosi followed by single-cycle rise/fall detectors.
// Ports:
//   clk, rst             system clock, async active-high reset
//   sclk, ss, mosi       raw SPI pins
//   sclk_rise/sclk_fall  one-cycle edge pulses of the conditioned sclk
//   ss_rise/ss_fall      one-cycle edge pulses of the conditioned ss
//   mosi_s               mosi delayed to line up with the sclk edge pulses
module spi_slave_sync #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic ss,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_rise,
    output logic ss_fall,
    output logic mosi_s
);

    logic sclk_s;
    logic ss_s;
    logic sclk_q;
    logic ss_q;

    // ss history resets low so that a select already asserted while in
    // reset never shows up as a fall once reset is released.
    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] sclk_ff;
            logic [1:0] ss_ff;
            logic [1:0] mosi_ff;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sclk_ff <= 2'b11;
                    ss_ff   <= 2'b00;
                    mosi_ff <= 2'b00;
                end else begin
                    sclk_ff <= {sclk_ff[0], sclk};
                    ss_ff   <= {ss_ff[0], ss};
                    mosi_ff <= {mosi_ff[0], mosi};
                end
            end

            assign sclk_s = sclk_ff[1];
            assign ss_s   = ss_ff[1];
            assign mosi_s = mosi_ff[1];
        end else begin : g_bypass
            assign sclk_s = sclk;
            assign ss_s   = ss;
            assign mosi_s = mosi;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= 1'b1;
            ss_q   <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            ss_q   <= ss_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign ss_rise   = ss_s & ~ss_q;
    assign ss_fall   = ~ss_s & ss_q;

endmodule

// File: rtl/spi_slave_fl.sv
// Flash-style SPI responder, mode 3 (sclk idle high), one frame per ss low.
// Takes an opcode, then address and/or write data as the opcode needs,
// and returns a 32-bit response word LSB first on miso.
// Ports:
//   clk, rst      system clock, async active-high reset
//   sclk, ss, mosi, miso   SPI pins
//   resp_data     READ response word, sampled the cycle resp_req is high
//   resp_req      pulse: READ address complete, addr_out valid
//   frame_valid   pulse one cycle after ss rises on an active frame
//   frame_err     qualifies frame_valid: truncated phase or unknown opcode
//   cmd_out, addr_out, wdata_out   last completed opcode/address/data
//   status        status register, bit1 = write enable latch
//
// state  | meaning
// IDLE   | no frame, waiting for ss fall
// CMD    | shifting the 8-bit opcode
// ADDR   | shifting the 24-bit address (READ, PP)
// WDATA  | shifting the 32-bit write data (PP, WRSR)
// RESP   | driving the response word on sclk falls
// DONE   | frame content complete, waiting for ss rise
module spi_slave_fl
    import spi_slave_fl_pkg::*;
#(
    parameter bit          SYNC_EN   = 1'b1,
    parameter logic [31:0] DEVICE_ID = 32'h001740EF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    input  logic [31:0] resp_data,
    output logic        resp_req,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  cmd_out,
    output logic [23:0] addr_out,
    output logic [31:0] wdata_out,
    output logic [7:0]  status
);

    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;
    logic mosi_s;

    spi_slave_sync #(
        .SYNC_EN (SYNC_EN)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_rise   (ss_rise),
        .ss_fall   (ss_fall),
        .mosi_s    (mosi_s)
    );

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [31:0]      shift_sr;
    logic [31:0]      shift_nxt;
    logic [31:0]      resp_word;
    logic [5:0]       resp_idx;
    logic             err_pend;

    logic rise_ok;
    logic fall_ok;
    logic bit_last;
    logic frame_end;
    logic end_err;

    // ss rise takes priority over a coincident sclk edge.
    assign rise_ok   = sclk_rise & ~ss_rise;
    assign fall_ok   = sclk_fall & ~ss_rise;
    assign bit_last  = (bit_cnt == '0);
    assign shift_nxt = {shift_sr[30:0], mosi_s};
    assign frame_end = ss_rise & (state != ST_IDLE);
    assign end_err   = err_pend | (state == ST_CMD) | (state == ST_ADDR) | (state == ST_WDATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ss_fall) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (rise_ok && bit_last) state_nxt = op_decode(shift_nxt[7:0]);
            end
            ST_ADDR: begin
                if (rise_ok && bit_last) state_nxt = (cmd_out == OP_READ) ? ST_RESP : ST_WDATA;
            end
            ST_WDATA: begin
                if (rise_ok && bit_last) state_nxt = ST_DONE;
            end
            default: state_nxt = state;
        endcase
        if (frame_end) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso        <= 1'b0;
            resp_req    <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            cmd_out     <= '0;
            addr_out    <= '0;
            wdata_out   <= '0;
            status      <= '0;
            bit_cnt     <= CMD_LOAD;
            shift_sr    <= '0;
            resp_word   <= '0;
            resp_idx    <= '0;
            err_pend    <= 1'b0;
        end else begin
            resp_req    <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (frame_end) begin
                frame_valid <= 1'b1;
                frame_err   <= end_err;
                miso        <= 1'b0;
                err_pend    <= 1'b0;
                // Only frames that ran to DONE cleanly touch the status register.
                if (!end_err && state == ST_DONE) begin
                    case (cmd_out)
                        OP_WREN: status[STATUS_WEL] <= 1'b1;
                        OP_PP:   status[STATUS_WEL] <= 1'b0;
                        OP_WRSR: begin
                            if (status[STATUS_WEL]) begin
                                status <= {wdata_out[7:2], 1'b0, wdata_out[0]};
                            end
                        end
                        default: ;
                    endcase
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        miso     <= 1'b0;
                        bit_cnt  <= CMD_LOAD;
                        resp_idx <= '0;
                        err_pend <= 1'b0;
                    end
                    ST_CMD: begin
                        if (rise_ok) begin
                            shift_sr <= shift_nxt;
                            if (bit_last) begin
                                cmd_out   <= shift_nxt[7:0];
                                err_pend  <= ~op_known(shift_nxt[7:0]);
                                bit_cnt   <= (shift_nxt[7:0] == OP_WRSR) ? DATA_LOAD : ADDR_LOAD;
                                resp_word <= (shift_nxt[7:0] == OP_RDSR) ? {24'h0, status} : DEVICE_ID;
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise_ok) begin
                            shift_sr <= shift_nxt;
                            if (bit_last) begin
                                addr_out <= shift_nxt[23:0];
                                bit_cnt  <= DATA_LOAD;
                                if (cmd_out == OP_READ) resp_req <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (rise_ok) begin
                            shift_sr <= shift_nxt;
                            if (bit_last) begin
                                wdata_out <= shift_nxt;
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                    ST_RESP: begin
                        // The first response fall is at least two clk after
                        // the last address rise, so this load always wins it.
                        if (resp_req) resp_word <= resp_data;
                        if (fall_ok) begin
                            if (!resp_idx[5]) begin
                                miso     <= resp_word[resp_idx[4:0]];
                                resp_idx <= resp_idx + 1'b1;
                            end else begin
                                miso <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_fl.sv
// Directed bench for spi_slave_fl: a behavioural mode-3 SPI master drives
// frames and the results are checked against hand-computed values.
module tb_spi_slave_fl;

    localparam int HALF = 80;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic [31:0] resp_data;
    logic        resp_req;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  cmd_out;
    logic [23:0] addr_out;
    logic [31:0] wdata_out;
    logic [7:0]  status;

    int n_cmp = 0;
    int n_err = 0;

    int          fv_cnt = 0;
    int          rr_cnt = 0;
    logic [23:0] rr_addr = '0;

    logic        got_fv;
    logic        got_err;
    logic [31:0] rd;

    spi_slave_fl #(
        .SYNC_EN   (1'b1),
        .DEVICE_ID (32'h001740EF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso),
        .resp_data   (resp_data),
        .resp_req    (resp_req),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .cmd_out     (cmd_out),
        .addr_out    (addr_out),
        .wdata_out   (wdata_out),
        .status      (status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (resp_req) begin
            rr_cnt++;
            rr_addr = addr_out;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spi_begin();
        ss = 1'b0;
        #(100);
    endtask

    task automatic spi_out(input logic [31:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sclk = 1'b0;
            mosi = d[i];
            #(HALF);
            sclk = 1'b1;
            #(HALF);
        end
    endtask

    task automatic spi_in(input int n, output logic [31:0] r);
        r = '0;
        for (int k = 0; k < n; k++) begin
            sclk = 1'b0;
            #(HALF);
            r[k] = miso;
            sclk = 1'b1;
            #(HALF);
        end
    endtask

    // Raise ss and wait (bounded) for the frame strobe.
    task automatic spi_end(output logic fv, output logic err);
        #(HALF);
        ss   = 1'b1;
        mosi = 1'b0;
        fv   = 1'b0;
        err  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_valid && !fv) begin
                fv  = 1'b1;
                err = frame_err;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        sclk      = 1'b1;
        ss        = 1'b1;
        mosi      = 1'b0;
        resp_data = 32'h0;
        repeat (5) @(negedge clk);

        chk("rst_miso", {31'h0, miso}, 32'h0);
        chk("rst_resp_req", {31'h0, resp_req}, 32'h0);
        chk("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        chk("rst_cmd", {24'h0, cmd_out}, 32'h0);
        chk("rst_addr", {8'h0, addr_out}, 32'h0);
        chk("rst_wdata", wdata_out, 32'h0);
        chk("rst_status", {24'h0, status}, 32'h0);

        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_no_frame", fv_cnt, 0);

        // READ_ID, full 32-bit response
        spi_begin();
        spi_out(32'h9F, 8);
        spi_in(32, rd);
        spi_end(got_fv, got_err);
        chk("rdid_data", rd, 32'h001740EF);
        chk("rdid_fv", {31'h0, got_fv}, 32'h1);
        chk("rdid_err", {31'h0, got_err}, 32'h0);
        chk("rdid_cmd", {24'h0, cmd_out}, 32'h9F);

        // READ with full and short response
        resp_data = 32'hDEADBEEF;
        spi_begin();
        spi_out(32'h03, 8);
        spi_out(32'h00A5C3, 24);
        spi_in(32, rd);
        spi_end(got_fv, got_err);
        chk("read_rr_cnt", rr_cnt, 1);
        chk("read_rr_addr", {8'h0, rr_addr}, 32'h00A5C3);
        chk("read_data", rd, 32'hDEADBEEF);
        chk("read_fv", {31'h0, got_fv}, 32'h1);
        chk("read_err", {31'h0, got_err}, 32'h0);

        spi_begin();
        spi_out(32'h03, 8);
        spi_out(32'h00A5C3, 24);
        spi_in(8, rd);
        spi_end(got_fv, got_err);
        chk("read8_data", rd, 32'h000000EF);
        chk("read8_err", {31'h0, got_err}, 32'h0);

        // WRSR without WREN leaves status alone
        spi_begin();
        spi_out(32'h01, 8);
        spi_out(32'h0000003D, 32);
        spi_end(got_fv, got_err);
        chk("wrsr_nowel_err", {31'h0, got_err}, 32'h0);
        chk("wrsr_nowel_wdata", wdata_out, 32'h0000003D);
        chk("wrsr_nowel_status", {24'h0, status}, 32'h00);

        // WREN then WRSR
        spi_begin();
        spi_out(32'h06, 8);
        spi_end(got_fv, got_err);
        chk("wren_status", {24'h0, status}, 32'h02);

        spi_begin();
        spi_out(32'h01, 8);
        spi_out(32'h0000003D, 32);
        spi_end(got_fv, got_err);
        chk("wrsr_status", {24'h0, status}, 32'h3D);

        spi_begin();
        spi_out(32'h05, 8);
        spi_in(8, rd);
        spi_end(got_fv, got_err);
        chk("rdsr_data", rd, 32'h3D);
        chk("rdsr_err", {31'h0, got_err}, 32'h0);

        // WREN then PP; PP clears WEL
        spi_begin();
        spi_out(32'h06, 8);
        spi_end(got_fv, got_err);
        chk("wren2_status", {24'h0, status}, 32'h3F);

        spi_begin();
        spi_out(32'h02, 8);
        spi_out(32'h000100, 24);
        spi_out(32'h12345678, 32);
        spi_end(got_fv, got_err);
        chk("pp_fv", {31'h0, got_fv}, 32'h1);
        chk("pp_err", {31'h0, got_err}, 32'h0);
        chk("pp_cmd", {24'h0, cmd_out}, 32'h02);
        chk("pp_addr", {8'h0, addr_out}, 32'h000100);
        chk("pp_wdata", wdata_out, 32'h12345678);
        chk("pp_status", {24'h0, status}, 32'h3D);
        chk("pp_no_rr", rr_cnt, 2);

        // Unknown opcode
        spi_begin();
        spi_out(32'hAB, 8);
        spi_in(8, rd);
        spi_end(got_fv, got_err);
        chk("badop_miso", rd, 32'h0);
        chk("badop_fv", {31'h0, got_fv}, 32'h1);
        chk("badop_err", {31'h0, got_err}, 32'h1);
        chk("badop_status", {24'h0, status}, 32'h3D);

        // Truncated address after WREN: error, no status change
        spi_begin();
        spi_out(32'h06, 8);
        spi_end(got_fv, got_err);
        spi_begin();
        spi_out(32'h02, 8);
        spi_out(32'h000ABC, 12);
        spi_end(got_fv, got_err);
        chk("trunc_fv", {31'h0, got_fv}, 32'h1);
        chk("trunc_err", {31'h0, got_err}, 32'h1);
        chk("trunc_status", {24'h0, status}, 32'h3F);
        chk("trunc_addr", {8'h0, addr_out}, 32'h000100);

        // Reset during READ response bit 10 (DEADBEEF bit 10 = 1)
        spi_begin();
        spi_out(32'h03, 8);
        spi_out(32'h000010, 24);
        spi_in(10, rd);
        sclk = 1'b0;
        #(HALF);
        chk("rst_pre_bits", rd, 32'h2EF);
        chk("rst_pre_miso", {31'h0, miso}, 32'h1);
        fv_cnt = 0;
        rst = 1'b1;
        #1;
        chk("rst_mid_miso", {31'h0, miso}, 32'h0);
        #9;
        sclk = 1'b1;
        ss   = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_fv", fv_cnt, 0);
        chk("rst_mid_status", {24'h0, status}, 32'h0);
        chk("rst_mid_cmd", {24'h0, cmd_out}, 32'h0);

        spi_begin();
        spi_out(32'h9F, 8);
        spi_in(32, rd);
        spi_end(got_fv, got_err);
        chk("post_rst_rdid", rd, 32'h001740EF);
        chk("post_rst_fv", {31'h0, got_fv}, 32'h1);
        chk("post_rst_err", {31'h0, got_err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
